// File: rtl/sm83_int_ctrl.sv
// sm83_int_ctrl -- SM83 interrupt controller and dispatch sequencer.
//
// Owns the IF register (FF0F) and the IME flag. At instruction boundaries it
// decides whether to take an interrupt, then runs the 5-M-cycle dispatch:
// WAIT0, WAIT1 (SP--), PUSH_HI (SP--, write PC[15:8]), PUSH_LO (write
// PC[7:0], clear IF bit), JUMP (load PC with the vector). It also handles
// HALT entry and wake-up.
//
// Optional feature macro: SM83_HALT_BUG_EN. When defined, HALT executed with
// IME=0 and an interrupt already pending does not halt; o_halt_bug pulses
// instead so the datapath fetches the next byte twice. When undefined,
// o_halt_bug is tied 0.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   i_m_tick            one-clk enable per M-cycle
//   i_instr_boundary    this M-cycle is the opcode fetch of the next instr
//   i_ei/di/reti/halt_exec  decoded control ops, valid with i_m_tick
//   i_irq_pulse         peripheral request strobes (any clk, sticky in IF)
//   i_ie                low bits of IE
//   i_if_we/i_if_wdata  CPU write to FF0F
//   i_pc                current PC, pushed during dispatch
//   o_if_rdata          {unused bits = 1, IF}
//   o_ime, o_halted, o_stall
//   o_addr_sel          addr_sel_t (NONE = 3'd0, SP = 3'd1)
//   o_mem_we/o_mem_wdata, o_sp_dec, o_pc_load/o_pc_vec, o_halt_bug

module sm83_int_ctrl #(
  parameter int          N_IRQ    = 5,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_m_tick,
  input  logic             i_instr_boundary,
  input  logic             i_ei_exec,
  input  logic             i_di_exec,
  input  logic             i_reti_exec,
  input  logic             i_halt_exec,
  input  logic [N_IRQ-1:0] i_irq_pulse,
  input  logic [N_IRQ-1:0] i_ie,
  input  logic             i_if_we,
  input  logic [N_IRQ-1:0] i_if_wdata,
  input  logic [15:0]      i_pc,
  output logic [7:0]       o_if_rdata,
  output logic             o_ime,
  output logic             o_halted,
  output logic             o_stall,
  output logic [2:0]       o_addr_sel,
  output logic             o_mem_we,
  output logic [7:0]       o_mem_wdata,
  output logic             o_sp_dec,
  output logic             o_pc_load,
  output logic [15:0]      o_pc_vec,
  output logic             o_halt_bug
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [2:0] ADDR_NONE = 3'd0;
  localparam logic [2:0] ADDR_SP   = 3'd1;

  typedef enum logic [2:0] {
    INT_IDLE    = 3'd0,
    INT_WAIT0   = 3'd1,
    INT_WAIT1   = 3'd2,
    INT_PUSH_HI = 3'd3,
    INT_PUSH_LO = 3'd4,
    INT_JUMP    = 3'd5
  } int_state_t;

  int_state_t       r_state;
  int_state_t       w_state_nxt;
  logic [N_IRQ-1:0] r_if;
  logic             r_ime;
  logic             r_ei_pend;
  logic             r_halted;
  logic [IDX_W-1:0] r_idx;

  logic [N_IRQ-1:0] w_pending;
  logic             w_any;
  logic             w_take;
  logic             w_halt_bug;
  logic [N_IRQ-1:0] w_if_clr;

  // Lowest set bit wins: bit 0 (VBlank) has the highest priority.
  function automatic logic [IDX_W-1:0] f_lowest_idx(input logic [N_IRQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign w_pending = r_if & i_ie;
  assign w_any     = |w_pending;
  assign w_take    = (r_state == INT_IDLE) & i_m_tick & i_instr_boundary & r_ime & w_any;
  assign w_if_clr  = (r_state == INT_PUSH_LO && i_m_tick) ? (N_IRQ'(1) << r_idx) : '0;

`ifdef SM83_HALT_BUG_EN
  assign w_halt_bug = i_m_tick & i_halt_exec & ~r_ime & w_any;
`else
  assign w_halt_bug = 1'b0;
`endif

  // IF register: updates every clk; a request set beats any clear in the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_if <= '0;
    else        r_if <= ((i_if_we ? i_if_wdata : r_if) & ~w_if_clr) | i_irq_pulse;
  end

  // IME and the delayed-EI flag; EI only arms IME at the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
    end else if (i_m_tick) begin
      if (w_take || i_di_exec) begin
        r_ime     <= 1'b0;
        r_ei_pend <= 1'b0;
      end else if (i_ei_exec) begin
        r_ei_pend <= 1'b1;
      end else if (i_reti_exec) begin
        r_ime     <= 1'b1;
      end else if (i_instr_boundary && r_ei_pend) begin
        r_ime     <= 1'b1;
        r_ei_pend <= 1'b0;
      end
    end
  end

  // HALT state: any pending request wakes the core regardless of IME.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (i_m_tick) begin
      if (r_halted) r_halted <= ~w_any;
      else          r_halted <= i_halt_exec & ~w_halt_bug;
    end
  end

  // Vector index is latched at entry so IE changes mid-dispatch are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_idx <= '0;
    else if (w_take) r_idx <= f_lowest_idx(w_pending);
  end

  // Dispatch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INT_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Dispatch next-state and per-M-cycle strobes (strobes gated by i_m_tick).
  always_comb begin
    w_state_nxt = r_state;
    o_addr_sel  = ADDR_NONE;
    o_mem_we    = 1'b0;
    o_mem_wdata = 8'h00;
    o_sp_dec    = 1'b0;
    o_pc_load   = 1'b0;
    o_pc_vec    = 16'h0000;
    case (r_state)
      INT_IDLE: begin
        if (w_take) w_state_nxt = INT_WAIT0;
        else        w_state_nxt = INT_IDLE;
      end
      INT_WAIT0: begin
        if (i_m_tick) w_state_nxt = INT_WAIT1;
        else          w_state_nxt = INT_WAIT0;
      end
      INT_WAIT1: begin
        o_sp_dec = i_m_tick;
        if (i_m_tick) w_state_nxt = INT_PUSH_HI;
        else          w_state_nxt = INT_WAIT1;
      end
      INT_PUSH_HI: begin
        o_addr_sel  = ADDR_SP;
        o_mem_we    = i_m_tick;
        o_mem_wdata = i_pc[15:8];
        o_sp_dec    = i_m_tick;
        if (i_m_tick) w_state_nxt = INT_PUSH_LO;
        else          w_state_nxt = INT_PUSH_HI;
      end
      INT_PUSH_LO: begin
        o_addr_sel  = ADDR_SP;
        o_mem_we    = i_m_tick;
        o_mem_wdata = i_pc[7:0];
        if (i_m_tick) w_state_nxt = INT_JUMP;
        else          w_state_nxt = INT_PUSH_LO;
      end
      INT_JUMP: begin
        o_pc_load = i_m_tick;
        o_pc_vec  = VEC_BASE + (16'(r_idx) << 3);
        if (i_m_tick) w_state_nxt = INT_IDLE;
        else          w_state_nxt = INT_JUMP;
      end
      default: begin
        w_state_nxt = INT_IDLE;
      end
    endcase
  end

  assign o_if_rdata = {{(8 - N_IRQ){1'b1}}, r_if};
  assign o_ime      = r_ime;
  assign o_halted   = r_halted;
  assign o_stall    = r_halted | (r_state != INT_IDLE);
  assign o_halt_bug = w_halt_bug;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Testbench for sm83_int_ctrl: scoreboard of expected per-M-cycle outputs,
// pushed when a tick is driven and compared by a monitor during that tick.
module tb_sm83_int_ctrl;

  localparam logic [2:0]  A_NONE = 3'd0;
  localparam logic [2:0]  A_SP   = 3'd1;
  localparam logic [29:0] B0     = 30'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_tick, instr_boundary, ei_exec, di_exec, reti_exec, halt_exec;
  logic [4:0]  irq_pulse, ie, if_wdata;
  logic        if_we;
  logic [15:0] pc;
  logic [7:0]  if_rdata, mem_wdata;
  logic        ime, halted, stall, mem_we, sp_dec, pc_load, halt_bug;
  logic [2:0]  addr_sel;
  logic [15:0] pc_vec;

  int n_chk = 0;
  int n_err = 0;

  string       tag_q[$];
  logic [41:0] exp_q[$];
  string       mon_tag;
  logic [41:0] mon_exp;

  always #5 clk = ~clk;

  sm83_int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_m_tick(m_tick), .i_instr_boundary(instr_boundary),
    .i_ei_exec(ei_exec), .i_di_exec(di_exec), .i_reti_exec(reti_exec), .i_halt_exec(halt_exec),
    .i_irq_pulse(irq_pulse), .i_ie(ie), .i_if_we(if_we), .i_if_wdata(if_wdata), .i_pc(pc),
    .o_if_rdata(if_rdata), .o_ime(ime), .o_halted(halted), .o_stall(stall),
    .o_addr_sel(addr_sel), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .o_sp_dec(sp_dec),
    .o_pc_load(pc_load), .o_pc_vec(pc_vec), .o_halt_bug(halt_bug)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] bus(input logic we, input logic [7:0] wd, input logic [2:0] as,
                                      input logic spd, input logic pl, input logic [15:0] pv);
    return {we, wd, as, spd, pl, pv};
  endfunction

  // Monitor: mid-cycle sample; ticks pop the scoreboard, other clks must be strobe-free.
  always @(negedge clk) begin
    #3;
    if (m_tick) begin
      chk("sb_has_exp", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_tag = tag_q.pop_front();
        mon_exp = exp_q.pop_front();
        chk({mon_tag, ".bus"}, 32'({mem_we, mem_wdata, addr_sel, sp_dec, pc_load, pc_vec}), 32'(mon_exp[41:12]));
        chk({mon_tag, ".ctl"}, 32'({stall, halted, ime, halt_bug}), 32'(mon_exp[11:8]));
        chk({mon_tag, ".if"}, 32'(if_rdata), 32'(mon_exp[7:0]));
      end
    end else begin
      chk("idle_strobe", 32'({mem_we, sp_dec, pc_load, halt_bug}), 32'd0);
    end
  end

  // One M-cycle tick followed by one clk without m_tick; ctl = {stall,halted,ime,halt_bug}.
  task automatic step(input string tag, input logic [29:0] eb, input logic [3:0] ec, input logic [7:0] ef);
    tag_q.push_back(tag);
    exp_q.push_back({eb, ec, ef});
    m_tick = 1'b1;
    @(negedge clk);
    m_tick = 1'b0; instr_boundary = 1'b0; ei_exec = 1'b0; di_exec = 1'b0;
    reti_exec = 1'b0; halt_exec = 1'b0; irq_pulse = 5'h00; if_we = 1'b0; if_wdata = 5'h00;
    @(negedge clk);
  endtask

  task automatic dispatch_seq(input string tag, input logic [15:0] pcv, input logic [15:0] vec,
                              input logic [7:0] if_b, input logic [7:0] if_a);
    step({tag, ".w0"}, B0, 4'b1000, if_b);
    step({tag, ".w1"}, bus(1'b0, 8'h00, A_NONE, 1'b1, 1'b0, 16'h0000), 4'b1000, if_b);
    step({tag, ".hi"}, bus(1'b1, pcv[15:8], A_SP, 1'b1, 1'b0, 16'h0000), 4'b1000, if_b);
    step({tag, ".lo"}, bus(1'b1, pcv[7:0], A_SP, 1'b0, 1'b0, 16'h0000), 4'b1000, if_b);
    step({tag, ".jp"}, bus(1'b0, 8'h00, A_NONE, 1'b0, 1'b1, vec), 4'b1000, if_a);
  endtask

  initial begin
    rst_n = 1'b0; m_tick = 1'b0; instr_boundary = 1'b0; ei_exec = 1'b0; di_exec = 1'b0;
    reti_exec = 1'b0; halt_exec = 1'b0; irq_pulse = 5'h00; ie = 5'h00; if_we = 1'b0;
    if_wdata = 5'h00; pc = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst.if", 32'(if_rdata), 32'h0000_00E0);
    chk("rst.ctl", 32'({stall, halted, ime, halt_bug}), 32'd0);
    chk("rst.bus", 32'({mem_we, mem_wdata, addr_sel, sp_dec, pc_load, pc_vec}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dispatch of source 2
    reti_exec = 1'b1;                        step("t1.reti", B0, 4'b0000, 8'hE0);
    ie = 5'h04; pc = 16'h1234; irq_pulse = 5'h04; step("t1.irq", B0, 4'b0010, 8'hE0);
    instr_boundary = 1'b1;                   step("t1.take", B0, 4'b0010, 8'hE4);
    dispatch_seq("t1", 16'h1234, 16'h0050, 8'hE4, 8'hE0);
    step("t1.after", B0, 4'b0000, 8'hE0);

    // All pending: source 0 wins; IE change mid-dispatch ignored
    if_we = 1'b1; if_wdata = 5'h1F; reti_exec = 1'b1; ie = 5'h1F;
    step("t2.set", B0, 4'b0000, 8'hE0);
    instr_boundary = 1'b1;                   step("t2.take", B0, 4'b0010, 8'hFF);
    ie = 5'h10;
    dispatch_seq("t2", 16'h1234, 16'h0040, 8'hFF, 8'hFE);
    ie = 5'h1F;                              step("t2.after", B0, 4'b0000, 8'hFE);

    // EI delay: first boundary not interrupted, next one is
    ei_exec = 1'b1;                          step("t3.ei", B0, 4'b0000, 8'hFE);
    instr_boundary = 1'b1;                   step("t3.b1", B0, 4'b0000, 8'hFE);
    step("t3.exe", B0, 4'b0010, 8'hFE);
    instr_boundary = 1'b1;                   step("t3.b2", B0, 4'b0010, 8'hFE);
    pc = 16'hABCD;
    dispatch_seq("t3", 16'hABCD, 16'h0048, 8'hFE, 8'hFC);

    // EI;DI leaves IME clear
    ei_exec = 1'b1;                          step("t4.ei", B0, 4'b0000, 8'hFC);
    di_exec = 1'b1;                          step("t4.di", B0, 4'b0000, 8'hFC);
    instr_boundary = 1'b1;                   step("t4.b1", B0, 4'b0000, 8'hFC);
    instr_boundary = 1'b1;                   step("t4.b2", B0, 4'b0000, 8'hFC);
    step("t4.chk", B0, 4'b0000, 8'hFC);

    // Write-clear and request in the same clk: request wins
    if_we = 1'b1; if_wdata = 5'h00;          step("t5.clr", B0, 4'b0000, 8'hFC);
    if_we = 1'b1; if_wdata = 5'h00; irq_pulse = 5'h02; step("t5.race", B0, 4'b0000, 8'hE0);
    step("t5.chk", B0, 4'b0000, 8'hE2);

    // HALT with IME=0: wake without dispatch
    if_we = 1'b1; if_wdata = 5'h00;          step("t6.clr", B0, 4'b0000, 8'hE2);
    ie = 5'h10; halt_exec = 1'b1;            step("t6.halt", B0, 4'b0000, 8'hE0);
    step("t6.h1", B0, 4'b1100, 8'hE0);
    irq_pulse = 5'h10;                       step("t6.irq", B0, 4'b1100, 8'hE0);
    step("t6.wake", B0, 4'b1100, 8'hF0);
    instr_boundary = 1'b1;                   step("t6.run", B0, 4'b0000, 8'hF0);
    step("t6.chk", B0, 4'b0000, 8'hF0);

    // HALT with IME=0 and a request already pending
    if_we = 1'b1; if_wdata = 5'h01; ie = 5'h1F; step("t7.set", B0, 4'b0000, 8'hF0);
    halt_exec = 1'b1;
`ifdef SM83_HALT_BUG_EN
    step("t7.halt", B0, 4'b0001, 8'hE1);
    step("t7.after", B0, 4'b0000, 8'hE1);
`else
    step("t7.halt", B0, 4'b0000, 8'hE1);
    step("t7.h", B0, 4'b1100, 8'hE1);
    step("t7.after", B0, 4'b0000, 8'hE1);
`endif

    // HALT with IME=1: wake, then dispatch at the boundary
    if_we = 1'b1; if_wdata = 5'h00; reti_exec = 1'b1; step("t8.set", B0, 4'b0000, 8'hE1);
    halt_exec = 1'b1;                        step("t8.halt", B0, 4'b0010, 8'hE0);
    irq_pulse = 5'h08;                       step("t8.irq", B0, 4'b1110, 8'hE0);
    step("t8.wake", B0, 4'b1110, 8'hE8);
    instr_boundary = 1'b1;                   step("t8.take", B0, 4'b0010, 8'hE8);
    pc = 16'h0150;
    dispatch_seq("t8", 16'h0150, 16'h0058, 8'hE8, 8'hE0);
    step("t8.after", B0, 4'b0000, 8'hE0);

    // Reset in the middle of a dispatch
    reti_exec = 1'b1;                        step("t9.reti", B0, 4'b0000, 8'hE0);
    irq_pulse = 5'h01;                       step("t9.irq", B0, 4'b0010, 8'hE0);
    instr_boundary = 1'b1;                   step("t9.take", B0, 4'b0010, 8'hE1);
    step("t9.w0", B0, 4'b1000, 8'hE1);
    step("t9.w1", bus(1'b0, 8'h00, A_NONE, 1'b1, 1'b0, 16'h0000), 4'b1000, 8'hE1);
    rst_n = 1'b0;
    #2;
    chk("t9.rst.if", 32'(if_rdata), 32'h0000_00E0);
    chk("t9.rst.ctl", 32'({stall, halted, ime, halt_bug}), 32'd0);
    chk("t9.rst.bus", 32'({mem_we, mem_wdata, addr_sel, sp_dec, pc_load, pc_vec}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step("t9.post", B0, 4'b0000, 8'hE0);
    step("t9.post2", B0, 4'b0000, 8'hE0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm83_int_ctrl.md
Name: sm83_int_ctrl

Overview:
- SM83 interrupt controller and dispatch sequencer. Sits beside the execute FSM.
- Owns the IF register (FF0F) and IME. Decides at instruction boundaries whether to take an interrupt.
- Runs the 5-M-cycle dispatch: push PC to the stack via the SP address path, then load the PC with the vector.
- Manages HALT entry and wake-up.

Parameters:
- N_IRQ, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad; bit 0 highest priority).
- VEC_BASE, 16'h0040, vector of source 0; source i vectors to VEC_BASE + 8*i.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m_tick  in  1  one-clk enable per M-cycle; all FSM/IME/halt updates qualify on it
- instr_boundary  in  1  current M-cycle is the opcode-fetch point of the next instruction
- ei_exec / di_exec / reti_exec / halt_exec  in  1 each  decoded CTL_EI / CTL_DI / CTL_RETI / CTL_HALT, valid with m_tick
- irq_pulse  in  N_IRQ  peripheral request strobes; any clk, sticky into IF
- ie  in  N_IRQ  low bits of IE register
- if_we  in  1  CPU write to FF0F; if_wdata  in  N_IRQ
- pc  in  16  current PC, pushed during dispatch
- if_rdata  out  8  {3'b111, IF}
- ime  out  1  master enable
- halted  out  1  core in HALT; the execute FSM holds EX_HALT
- stall  out  1  halted OR dispatch active; fetch/execute frozen
- addr_sel  out  3  addr_sel_t: SP during push cycles, else NONE
- mem_we  out  1  bus write strobe; mem_wdata  out  8
- sp_dec  out  1  decrement SP this M-cycle
- pc_load  out  1  load PC from pc_vec this M-cycle; pc_vec  out  16
- halt_bug  out  1  suppress next PC increment (optional feature)

Behaviour:
- Reset: IF=0, IME=0, ei_pend=0, halted=0, FSM=INT_IDLE. All strobes 0, addr_sel=NONE, pc_vec=0, if_rdata=8'hE0.
- IF update, any clk: IF <= (if_we ? if_wdata : IF) | irq_pulse. Set wins over a write-clear and over dispatch-clear in the same clk.
- pending = IF & ie. Selected index = lowest set bit of pending.
- IME rules (on m_tick):
  - di_exec: IME=0 and ei_pend=0.
  - ei_exec: ei_pend=1. IME becomes 1 at the next instr_boundary tick, after that instruction's fetch. The instruction after EI is therefore never interrupted. EI;DI leaves IME=0.
  - reti_exec: IME=1 immediately.
- Dispatch entry: FSM=INT_IDLE, m_tick, instr_boundary, IME=1, pending!=0. On entry: IME=0, ei_pend=0, index latched.
- Dispatch FSM, one state per m_tick, total 5 M-cycles:
  - INT_WAIT0: no strobes.
  - INT_WAIT1: sp_dec=1.
  - INT_PUSH_HI: addr_sel=SP, mem_we=1, mem_wdata=pc[15:8], sp_dec=1.
  - INT_PUSH_LO: addr_sel=SP, mem_we=1, mem_wdata=pc[7:0]; clear IF[index].
  - INT_JUMP: pc_load=1, pc_vec=VEC_BASE+8*index; then return to INT_IDLE.
- Strobes are combinational from state and gated by m_tick, so each pulses exactly one clk.
- stall=1 in every non-IDLE state.
- HALT:
  - halt_exec tick: halted=1.
  - While halted: any pending!=0 on a tick clears halted, regardless of IME.
  - If IME=1, dispatch starts at the next instr_boundary. If IME=0, execution resumes without dispatch.
- ie changes mid-dispatch do not alter the latched index.
- Reset mid-dispatch: immediate return to the reset state, no partial push completed.

Optional Feature:
- Macro: SM83_HALT_BUG_EN.
- Defined: halt_exec with IME=0 and pending!=0 does not set halted. Instead halt_bug pulses for one m_tick, so the datapath fetches the next byte twice.
- Undefined: halted is set and exits on the following tick. halt_bug is tied 0.

Test Plan:
- ie=5'h04, IME=1, irq_pulse[2], pc=16'h1234 at boundary → writes 8'h12 then 8'h34 with addr_sel=SP on consecutive ticks, sp_dec in WAIT1/PUSH_HI, pc_vec=16'h0050, IF[2]=0, ime=0.
- IF=5'h1F, ie=5'h1F → vector 16'h0040; IF reads 8'hFE afterwards.
- EI then pending at the immediately following boundary → no dispatch; dispatch at the next boundary.
- HALT with IME=0, IF=0, then irq_pulse[4] with ie[4]=1 → halted drops next tick, no mem_we, IF[4] stays 1.
- if_we with if_wdata=0 in the same clk as irq_pulse[1] → IF[1]=1.
- With SM83_HALT_BUG_EN: IME=0, pending=5'h01, halt_exec → halted stays 0, halt_bug one tick; without the macro: halted=1 for one tick.
